// File: rtl/uart_tx_port.sv
// uart_tx_port: Z80 I/O-mapped 8N1 serial transmitter.
// CPU OUT writes are buffered in a small FIFO and serialised on tx.
// An IN from the status register returns {5'b0, overflow, full, busy}.
//
// state | meaning
// IDLE  | line high; pops the FIFO head as soon as one is present
// START | start bit, tx=0 for DIVISOR cycles
// DATA  | eight data bits, LSB first, DIVISOR cycles each
// STOP  | stop bit, tx=1 for DIVISOR cycles
module uart_tx_port #(
   parameter int DIVISOR    = 434,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       masterclk,
   input  logic       reset_n,
   input  logic       ena,
   input  logic       iowr,
   input  logic       iord,
   input  logic       addr0,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       tx,
   output logic       irq_n
);

   localparam int BW = $clog2(DIVISOR);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;

   state_t        state, state_nx;
   logic [BW-1:0] bcnt, bcnt_nx;
   logic [2:0]    bidx, bidx_nx;
   logic [7:0]    shreg, shreg_nx;
   logic          tx_nx;
   logic          pop;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;

   logic          wr_q, rd_q;
   logic          overflow, ovf_hold;
   logic          wr_ev, rd_ev, push;
   logic          empty, full, busy;

   assign wr_ev = ena & iowr & ~wr_q;
   assign rd_ev = ena & iord & ~rd_q;
   assign empty = (count == '0);
   assign full  = (count == CW'(FIFO_DEPTH));
   assign busy  = (state != ST_IDLE) | ~empty;
   // A full FIFO still accepts a byte when the head leaves on the same edge.
   assign push  = wr_ev & ~addr0 & (~full | pop);

   // FIFO storage; contents are don't-care once count says empty.
   always_ff @(posedge masterclk) begin
      if (push) mem[wr_ptr] <= din;
   end

   // FIFO pointers and occupancy; a simultaneous push and pop leave count unchanged.
   always_ff @(posedge masterclk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push & ~pop)      count <= count + 1'b1;
         else if (pop & ~push) count <= count - 1'b1;
      end
   end

   // Bus side: strobe edge detect, registered readback, sticky overflow, interrupt.
   // ovf_hold keeps the pre-clear overflow visible for the rest of the read strobe.
   always_ff @(posedge masterclk) begin
      if (!reset_n) begin
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         dout     <= 8'h00;
         overflow <= 1'b0;
         ovf_hold <= 1'b0;
         irq_n    <= 1'b0;
      end else begin
         wr_q <= ena & iowr;
         rd_q <= ena & iord;
         if (ena & iord & addr0)
            dout <= {5'b0, (rd_q ? ovf_hold : overflow), full, busy};
         else
            dout <= 8'h00;
         if (rd_ev) ovf_hold <= overflow;
         if (wr_ev & ~addr0 & full & ~pop) overflow <= 1'b1;
         else if (rd_ev & addr0)           overflow <= 1'b0;
         irq_n <= ~(empty & (state == ST_IDLE));
      end
   end

   // Transmit FSM state register; tx is registered from the next-state decode.
   always_ff @(posedge masterclk) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         bcnt  <= '0;
         bidx  <= '0;
         shreg <= '0;
         tx    <= 1'b1;
      end else begin
         state <= state_nx;
         bcnt  <= bcnt_nx;
         bidx  <= bidx_nx;
         shreg <= shreg_nx;
         tx    <= tx_nx;
      end
   end

   // Transmit FSM next-state, baud timing, FIFO pop and line level.
   always_comb begin
      state_nx = state;
      bcnt_nx  = bcnt;
      bidx_nx  = bidx;
      shreg_nx = shreg;
      pop      = 1'b0;
      tx_nx    = 1'b1;
      case (state)
         ST_IDLE: begin
            if (!empty) begin
               pop      = 1'b1;
               shreg_nx = mem[rd_ptr];
               bcnt_nx  = BW'(DIVISOR - 1);
               state_nx = ST_START;
            end
         end
         ST_START: begin
            if (bcnt == '0) begin
               bcnt_nx  = BW'(DIVISOR - 1);
               bidx_nx  = 3'd0;
               state_nx = ST_DATA;
            end else begin
               bcnt_nx = bcnt - 1'b1;
            end
         end
         ST_DATA: begin
            if (bcnt == '0) begin
               bcnt_nx = BW'(DIVISOR - 1);
               if (bidx == 3'd7) state_nx = ST_STOP;
               else              bidx_nx  = bidx + 3'd1;
            end else begin
               bcnt_nx = bcnt - 1'b1;
            end
         end
         ST_STOP: begin
            if (bcnt == '0) state_nx = ST_IDLE;
            else            bcnt_nx  = bcnt - 1'b1;
         end
         default: state_nx = ST_IDLE;
      endcase
      case (state_nx)
         ST_START: tx_nx = 1'b0;
         ST_DATA:  tx_nx = shreg_nx[bidx_nx];
         default:  tx_nx = 1'b1;
      endcase
   end

endmodule
